// File: rtl/button_hit_detector.sv
// Turns raw asynchronous player buttons into debounced levels and single-cycle
// hit events, reported one per cycle, lowest index first.
module button_hit_detector #(
    parameter int unsigned CLOCK_FREQ  = 50_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned NUM_BUTTONS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn,
    input  logic                   enable,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic                   hit_valid,
    output logic [2:0]             hit_idx,
    output logic                   multi_press
);

    localparam int unsigned D_RAW = (CLOCK_FREQ * DEBOUNCE_MS) / 1000;
    localparam int unsigned D     = (D_RAW < 1) ? 1 : D_RAW;
    localparam int unsigned CNT_W = (D < 2) ? 1 : $clog2(D + 1);
    localparam int unsigned POP_W = 4;

    logic [NUM_BUTTONS-1:0] s1;
    logic [NUM_BUTTONS-1:0] s2;
    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] stable_d;
    logic [NUM_BUTTONS-1:0] new_press;
    logic [NUM_BUTTONS-1:0] pending;

    logic [NUM_BUTTONS-1:0] merged;
    logic [NUM_BUTTONS-1:0] lowest_mask;
    logic [2:0]             lowest_idx;
    logic                   found;
    logic [POP_W-1:0]       press_cnt;

    // Two-flop synchronizer on every raw button level
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Per-button debounce: a level must differ for D consecutive cycles
    for (genvar g = 0; g < int'(NUM_BUTTONS); g++) begin : g_debounce
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt       <= '0;
                stable[g] <= 1'b0;
            end else if (s2[g] == stable[g]) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(D - 1)) begin
                stable[g] <= s2[g];
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign btn_state = stable;

    // Merge queued and fresh presses, pick the lowest index, count fresh presses
    always_comb begin
        merged      = pending | (enable ? new_press : '0);
        lowest_mask = '0;
        lowest_idx  = '0;
        found       = 1'b0;
        press_cnt   = '0;
        for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
            if (merged[i] && !found) begin
                found          = 1'b1;
                lowest_idx     = 3'(i);
                lowest_mask[i] = 1'b1;
            end
            press_cnt = press_cnt + POP_W'(new_press[i]);
        end
    end

    // Rising-edge detect on the debounced level, then the hit queue
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d    <= '0;
            new_press   <= '0;
            pending     <= '0;
            hit_valid   <= 1'b0;
            hit_idx     <= '0;
            multi_press <= 1'b0;
        end else begin
            stable_d    <= stable;
            new_press   <= stable & ~stable_d;
            multi_press <= enable && (press_cnt >= POP_W'(2));
            if (!enable) begin
                pending   <= '0;
                hit_valid <= 1'b0;
            end else if (found) begin
                hit_valid <= 1'b1;
                hit_idx   <= lowest_idx;
                pending   <= merged & ~lowest_mask;
            end else begin
                hit_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_hit_detector.sv
// Directed bench for button_hit_detector with D = 4 (1 kHz clock, 4 ms debounce).
module tb_button_hit_detector;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       enable;
    logic [3:0] btn_state;
    logic       hit_valid;
    logic [2:0] hit_idx;
    logic       multi_press;

    int checks;
    int errors;

    int         hit_q[$];
    int         hit_cyc_q[$];
    int         multi_cnt;
    int         multi_cyc;
    int         cyc;
    logic [3:0] state_or;

    button_hit_detector #(
        .CLOCK_FREQ (1000),
        .DEBOUNCE_MS(4),
        .NUM_BUTTONS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .enable     (enable),
        .btn_state  (btn_state),
        .hit_valid  (hit_valid),
        .hit_idx    (hit_idx),
        .multi_press(multi_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; observe and drive 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        hit_q.delete();
        hit_cyc_q.delete();
        multi_cnt = 0;
        multi_cyc = -1;
        cyc       = 0;
        state_or  = '0;
    endtask

    // Run n cycles recording hits, multi-press pulses and any debounced level seen
    task automatic collect(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            cyc++;
            if (hit_valid === 1'b1) begin
                hit_q.push_back(int'(hit_idx));
                hit_cyc_q.push_back(cyc);
            end
            if (multi_press === 1'b1) begin
                multi_cnt++;
                multi_cyc = cyc;
            end
            state_or = state_or | btn_state;
        end
    endtask

    task automatic settle();
        btn = 4'b0000;
        clear_log();
        collect(12);
        checks++;
        if (hit_q.size() != 0 || btn_state !== 4'b0000) begin
            errors++;
            $display("FAIL settle: hits=%0d btn_state=%b, required hits=0 btn_state=0000",
                     hit_q.size(), btn_state);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btn    = 4'b1111;
        enable = 1'b1;
        repeat (3) step();
        checks++;
        if (btn_state !== 4'b0000 || hit_valid !== 1'b0 || hit_idx !== 3'd0 || multi_press !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: btn_state=%b hit_valid=%b hit_idx=%0d multi=%b, required all 0",
                     btn_state, hit_valid, hit_idx, multi_press);
        end
        rst = 1'b0;
        repeat (5) step();
        checks++;
        if (btn_state !== 4'b0000) begin
            errors++;
            $display("FAIL reset_early_state: btn_state=%b required 0000", btn_state);
        end
        step();
        checks++;
        if (btn_state !== 4'b1111) begin
            errors++;
            $display("FAIL reset_debounced: btn_state=%b required 1111", btn_state);
        end
        step();
        checks++;
        if (hit_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hit_early: hit_valid=%b required 0", hit_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (hit_valid !== 1'b1 || hit_idx !== 3'(k) || multi_press !== (k == 0)) begin
                errors++;
                $display("FAIL reset_hit_%0d: hit_valid=%b hit_idx=%0d multi=%b, required 1 %0d %b",
                         k, hit_valid, hit_idx, multi_press, k, (k == 0));
            end
        end
        step();
        checks++;
        if (hit_valid !== 1'b0 || multi_press !== 1'b0) begin
            errors++;
            $display("FAIL reset_hit_end: hit_valid=%b multi=%b required 0 0", hit_valid, multi_press);
        end
        settle();
    endtask

    task automatic test_clean_press();
        btn = 4'b0100;
        repeat (5) step();
        checks++;
        if (btn_state !== 4'b0000) begin
            errors++;
            $display("FAIL press_early: btn_state=%b required 0000", btn_state);
        end
        step();
        checks++;
        if (btn_state !== 4'b0100 || hit_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_state: btn_state=%b hit_valid=%b required 0100 0", btn_state, hit_valid);
        end
        step();
        checks++;
        if (hit_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_hit_early: hit_valid=%b required 0", hit_valid);
        end
        step();
        checks++;
        if (hit_valid !== 1'b1 || hit_idx !== 3'd2) begin
            errors++;
            $display("FAIL press_hit: hit_valid=%b hit_idx=%0d required 1 2", hit_valid, hit_idx);
        end
        clear_log();
        collect(20);
        checks++;
        if (hit_q.size() != 0) begin
            errors++;
            $display("FAIL press_single: extra hits=%0d required 0", hit_q.size());
        end
        btn = 4'b0000;
        repeat (5) step();
        checks++;
        if (btn_state !== 4'b0100) begin
            errors++;
            $display("FAIL release_early: btn_state=%b required 0100", btn_state);
        end
        step();
        checks++;
        if (btn_state !== 4'b0000) begin
            errors++;
            $display("FAIL release_state: btn_state=%b required 0000", btn_state);
        end
        clear_log();
        collect(10);
        checks++;
        if (hit_q.size() != 0) begin
            errors++;
            $display("FAIL release_no_hit: hits=%0d required 0", hit_q.size());
        end
    endtask

    task automatic test_bounce();
        clear_log();
        btn = 4'b0001;
        collect(3);
        btn = 4'b0000;
        collect(12);
        checks++;
        if (state_or !== 4'b0000 || hit_q.size() != 0) begin
            errors++;
            $display("FAIL short_glitch: state_or=%b hits=%0d required 0000 0", state_or, hit_q.size());
        end
        clear_log();
        for (int k = 0; k < 4; k++) begin
            btn = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            collect(1);
        end
        checks++;
        if (hit_q.size() != 0 || state_or !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_toggle: hits=%0d state_or=%b required 0 0000", hit_q.size(), state_or);
        end
        clear_log();
        btn = 4'b0010;
        collect(12);
        checks++;
        if (hit_q.size() != 1 || btn_state !== 4'b0010) begin
            errors++;
            $display("FAIL bounce_count: hits=%0d btn_state=%b required 1 0010", hit_q.size(), btn_state);
        end else begin
            checks++;
            if (hit_q[0] != 1 || hit_cyc_q[0] != 8) begin
                errors++;
                $display("FAIL bounce_hit: idx=%0d cyc=%0d required 1 8", hit_q[0], hit_cyc_q[0]);
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        clear_log();
        btn = 4'b1010;
        collect(14);
        checks++;
        if (hit_q.size() != 2) begin
            errors++;
            $display("FAIL simul_count: hits=%0d required 2", hit_q.size());
        end else begin
            checks++;
            if (hit_q[0] != 1 || hit_q[1] != 3 || hit_cyc_q[0] != 8 || hit_cyc_q[1] != 9) begin
                errors++;
                $display("FAIL simul_order: idx=%0d,%0d cyc=%0d,%0d required 1,3 8,9",
                         hit_q[0], hit_q[1], hit_cyc_q[0], hit_cyc_q[1]);
            end
        end
        checks++;
        if (multi_cnt != 1 || multi_cyc != 8) begin
            errors++;
            $display("FAIL simul_multi: pulses=%0d cyc=%0d required 1 8", multi_cnt, multi_cyc);
        end
        checks++;
        if (hit_valid !== 1'b0 || hit_idx !== 3'd3) begin
            errors++;
            $display("FAIL idx_hold: hit_valid=%b hit_idx=%0d required 0 3", hit_valid, hit_idx);
        end
        settle();
    endtask

    task automatic test_enable_gating();
        enable = 1'b0;
        clear_log();
        btn = 4'b0101;
        collect(12);
        checks++;
        if (hit_q.size() != 0 || btn_state !== 4'b0101 || multi_cnt != 0) begin
            errors++;
            $display("FAIL gate_disabled: hits=%0d btn_state=%b multi=%0d required 0 0101 0",
                     hit_q.size(), btn_state, multi_cnt);
        end
        enable = 1'b1;
        clear_log();
        collect(10);
        checks++;
        if (hit_q.size() != 0) begin
            errors++;
            $display("FAIL gate_reenable: hits=%0d required 0", hit_q.size());
        end
        settle();
    endtask

    task automatic test_reset_mid_queue();
        btn = 4'b1101;
        repeat (8) step();
        checks++;
        if (hit_valid !== 1'b1 || hit_idx !== 3'd0) begin
            errors++;
            $display("FAIL midq_first: hit_valid=%b hit_idx=%0d required 1 0", hit_valid, hit_idx);
        end
        rst = 1'b1;
        step();
        checks++;
        if (hit_valid !== 1'b0 || btn_state !== 4'b0000 || hit_idx !== 3'd0) begin
            errors++;
            $display("FAIL midq_reset: hit_valid=%b btn_state=%b hit_idx=%0d required 0 0000 0",
                     hit_valid, btn_state, hit_idx);
        end
        rst = 1'b0;
        clear_log();
        collect(15);
        checks++;
        if (hit_q.size() != 3) begin
            errors++;
            $display("FAIL midq_count: hits=%0d required 3", hit_q.size());
        end else begin
            checks++;
            if (hit_q[0] != 0 || hit_q[1] != 2 || hit_q[2] != 3 || hit_cyc_q[0] != 8) begin
                errors++;
                $display("FAIL midq_order: idx=%0d,%0d,%0d first_cyc=%0d required 0,2,3 8",
                         hit_q[0], hit_q[1], hit_q[2], hit_cyc_q[0]);
            end
        end
        checks++;
        if (btn_state !== 4'b1101 || multi_cnt != 1) begin
            errors++;
            $display("FAIL midq_state: btn_state=%b multi=%0d required 1101 1", btn_state, multi_cnt);
        end
        settle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_enable_gating();
        test_reset_mid_queue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
